mac_pwr_seq: RTL and testbench

- Power-sequencing controller for the Ethernet MAC power domain.
- Sits directly downstream of the MAC subsystem. It consumes the MAC idle interrupt and wakeup indications, plus software sleep/wake requests.
- Drives the clock-gate, isolation, retention save/restore and two-stage power-switch controls for the MAC domain in the correct order, and reports sequencer state back to the APB register block.

---
 rtl/mac_pwr_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_mac_pwr_seq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pwr_seq.sv
// Power-sequencing controller for the Ethernet MAC power domain: orders clock gating,
// isolation, retention save/restore and the two-stage power switches on sleep and wake.
module mac_pwr_seq #(
  parameter int unsigned SAVE_DLY = 2,
  parameter int unsigned PWR_DLY  = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       pclk,
  input  logic       n_preset,
  input  logic       sleep_en,
  input  logic       macb_idle_int,
  input  logic       macb_wakeup,
  input  logic       sw_sleep_req,
  input  logic       sw_wake_req,
  output logic       gate_clk_mac,
  output logic       isolate_mac,
  output logic       save_edge_mac,
  output logic       restore_edge_mac,
  output logic       pwr1_on_mac,
  output logic       pwr2_on_mac,
  output logic [3:0] mac_pwr_state,
  output logic       pwr_seq_busy,
  output logic       pwr_seq_done
);

  localparam int unsigned ST_W = 4;

  localparam logic [ST_W-1:0] ST_ON       = 4'd0;
  localparam logic [ST_W-1:0] ST_GATE     = 4'd1;
  localparam logic [ST_W-1:0] ST_ISO      = 4'd2;
  localparam logic [ST_W-1:0] ST_SAVE     = 4'd3;
  localparam logic [ST_W-1:0] ST_PWR2_OFF = 4'd4;
  localparam logic [ST_W-1:0] ST_PWR1_OFF = 4'd5;
  localparam logic [ST_W-1:0] ST_OFF      = 4'd6;
  localparam logic [ST_W-1:0] ST_PWR1_ON  = 4'd7;
  localparam logic [ST_W-1:0] ST_PWR2_ON  = 4'd8;
  localparam logic [ST_W-1:0] ST_RESTORE  = 4'd9;
  localparam logic [ST_W-1:0] ST_DEISO    = 4'd10;
  localparam logic [ST_W-1:0] ST_UNGATE   = 4'd11;

  localparam logic [CNT_W-1:0] SAVE_LOAD = CNT_W'(SAVE_DLY - 1);
  localparam logic [CNT_W-1:0] PWR_LOAD  = CNT_W'(PWR_DLY - 1);

  logic [ST_W-1:0]  r_state;
  logic [ST_W-1:0]  w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_wake_pend;
  logic             w_wake_pend_nxt;
  logic             r_idle_q;
  logic             r_idle_arm;

  logic w_wake_trig;
  logic w_sleep_trig;
  logic w_idle_rise;
  logic w_cnt_zero;
  logic w_in_pwr_down;

  logic w_gate;
  logic w_iso;
  logic w_save;
  logic w_restore;
  logic w_pwr1;
  logic w_pwr2;
  logic w_busy;
  logic w_done;

  // r_idle_arm masks the first cycle after reset so a level already high is not an edge
  assign w_idle_rise   = macb_idle_int & ~r_idle_q & r_idle_arm;
  assign w_wake_trig   = macb_wakeup | sw_wake_req;
  assign w_sleep_trig  = sw_sleep_req | (sleep_en & w_idle_rise);
  assign w_cnt_zero    = (r_cnt == '0);
  assign w_in_pwr_down = (r_state >= ST_GATE) && (r_state <= ST_PWR1_OFF);

  // State, delay counter, pending wake and idle edge-detect registers
  always_ff @(posedge pclk or negedge n_preset) begin
    if (!n_preset) begin
      r_state     <= ST_ON;
      r_cnt       <= '0;
      r_wake_pend <= 1'b0;
      r_idle_q    <= 1'b0;
      r_idle_arm  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_wake_pend <= w_wake_pend_nxt;
      r_idle_q    <= macb_idle_int;
      r_idle_arm  <= 1'b1;
    end
  end

  // Next-state, counter and pending-wake logic
  always_comb begin
    w_state_nxt     = r_state;
    w_wake_pend_nxt = r_wake_pend;
    w_cnt_nxt       = w_cnt_zero ? '0 : r_cnt - CNT_W'(1);

    case (r_state)
      ST_ON:       if (!w_wake_trig && w_sleep_trig) w_state_nxt = ST_GATE;
      ST_GATE:     w_state_nxt = ST_ISO;
      ST_ISO:      w_state_nxt = ST_SAVE;
      ST_SAVE:     if (w_cnt_zero) w_state_nxt = ST_PWR2_OFF;
      ST_PWR2_OFF: if (w_cnt_zero) w_state_nxt = ST_PWR1_OFF;
      ST_PWR1_OFF: if (w_cnt_zero) w_state_nxt = ST_OFF;
      ST_OFF: begin
        if (w_wake_trig || r_wake_pend) begin
          w_state_nxt     = ST_PWR1_ON;
          w_wake_pend_nxt = 1'b0;
        end
      end
      ST_PWR1_ON:  if (w_cnt_zero) w_state_nxt = ST_PWR2_ON;
      ST_PWR2_ON:  if (w_cnt_zero) w_state_nxt = ST_RESTORE;
      ST_RESTORE:  w_state_nxt = ST_DEISO;
      ST_DEISO:    w_state_nxt = ST_UNGATE;
      ST_UNGATE:   w_state_nxt = ST_ON;
      default:     w_state_nxt = ST_ON;
    endcase

    // A wake arriving mid power-down is remembered and honoured once OFF is reached
    if (w_in_pwr_down && w_wake_trig) w_wake_pend_nxt = 1'b1;

    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        ST_SAVE:     w_cnt_nxt = SAVE_LOAD;
        ST_PWR2_OFF,
        ST_PWR1_OFF,
        ST_PWR1_ON,
        ST_PWR2_ON:  w_cnt_nxt = PWR_LOAD;
        default:     w_cnt_nxt = '0;
      endcase
    end
  end

  // Domain controls decoded from the current state; illegal codes look like ON
  always_comb begin
    w_gate    = 1'b0;
    w_iso     = 1'b0;
    w_save    = 1'b0;
    w_restore = 1'b0;
    w_pwr1    = 1'b1;
    w_pwr2    = 1'b1;
    w_busy    = 1'b0;
    w_done    = 1'b0;

    case (r_state)
      ST_GATE: begin
        w_gate = 1'b1;
        w_busy = 1'b1;
      end
      ST_ISO: begin
        w_gate = 1'b1;
        w_iso  = 1'b1;
        w_busy = 1'b1;
      end
      ST_SAVE: begin
        w_gate = 1'b1;
        w_iso  = 1'b1;
        w_save = 1'b1;
        w_busy = 1'b1;
      end
      ST_PWR2_OFF, ST_PWR1_ON: begin
        w_gate = 1'b1;
        w_iso  = 1'b1;
        w_pwr2 = 1'b0;
        w_busy = 1'b1;
      end
      ST_PWR1_OFF: begin
        w_gate = 1'b1;
        w_iso  = 1'b1;
        w_pwr1 = 1'b0;
        w_pwr2 = 1'b0;
        w_busy = 1'b1;
      end
      ST_OFF: begin
        w_gate = 1'b1;
        w_iso  = 1'b1;
        w_pwr1 = 1'b0;
        w_pwr2 = 1'b0;
      end
      ST_PWR2_ON: begin
        w_gate = 1'b1;
        w_iso  = 1'b1;
        w_busy = 1'b1;
      end
      ST_RESTORE: begin
        w_gate    = 1'b1;
        w_iso     = 1'b1;
        w_restore = 1'b1;
        w_busy    = 1'b1;
      end
      ST_DEISO: begin
        w_gate = 1'b1;
        w_busy = 1'b1;
      end
      ST_UNGATE: w_busy = 1'b1;
      default: ;
    endcase

    // mac_pwr_state still holds the previous state, so a difference marks arrival
    if (((r_state == ST_ON) || (r_state == ST_OFF)) && (r_state != mac_pwr_state))
      w_done = 1'b1;
  end

  // Output registers
  always_ff @(posedge pclk or negedge n_preset) begin
    if (!n_preset) begin
      gate_clk_mac     <= 1'b0;
      isolate_mac      <= 1'b0;
      save_edge_mac    <= 1'b0;
      restore_edge_mac <= 1'b0;
      pwr1_on_mac      <= 1'b1;
      pwr2_on_mac      <= 1'b1;
      mac_pwr_state    <= ST_ON;
      pwr_seq_busy     <= 1'b0;
      pwr_seq_done     <= 1'b0;
    end else begin
      gate_clk_mac     <= w_gate;
      isolate_mac      <= w_iso;
      save_edge_mac    <= w_save;
      restore_edge_mac <= w_restore;
      pwr1_on_mac      <= w_pwr1;
      pwr2_on_mac      <= w_pwr2;
      mac_pwr_state    <= r_state;
      pwr_seq_busy     <= w_busy;
      pwr_seq_done     <= w_done;
    end
  end

endmodule

// File: tb/tb_mac_pwr_seq.sv
// Self-checking bench for mac_pwr_seq: directed sequence timing plus randomized traffic
// compared every cycle against a position-along-the-sequence model.
module tb_mac_pwr_seq;

  localparam int SAVE_DLY = 2;
  localparam int PWR_DLY  = 8;
  localparam int DOWN_LEN = 2 + SAVE_DLY + 2 * PWR_DLY;
  localparam int UP_LEN   = 2 * PWR_DLY + 3;

  localparam int M_ON   = 0;
  localparam int M_DOWN = 1;
  localparam int M_OFF  = 2;
  localparam int M_UP   = 3;

  logic       pclk;
  logic       n_preset;
  logic       sleep_en;
  logic       macb_idle_int;
  logic       macb_wakeup;
  logic       sw_sleep_req;
  logic       sw_wake_req;
  logic       gate_clk_mac;
  logic       isolate_mac;
  logic       save_edge_mac;
  logic       restore_edge_mac;
  logic       pwr1_on_mac;
  logic       pwr2_on_mac;
  logic [3:0] mac_pwr_state;
  logic       pwr_seq_busy;
  logic       pwr_seq_done;

  int checks = 0;
  int errors = 0;

  mac_pwr_seq #(.SAVE_DLY(SAVE_DLY), .PWR_DLY(PWR_DLY), .CNT_W(8)) dut (
    .pclk             (pclk),
    .n_preset         (n_preset),
    .sleep_en         (sleep_en),
    .macb_idle_int    (macb_idle_int),
    .macb_wakeup      (macb_wakeup),
    .sw_sleep_req     (sw_sleep_req),
    .sw_wake_req      (sw_wake_req),
    .gate_clk_mac     (gate_clk_mac),
    .isolate_mac      (isolate_mac),
    .save_edge_mac    (save_edge_mac),
    .restore_edge_mac (restore_edge_mac),
    .pwr1_on_mac      (pwr1_on_mac),
    .pwr2_on_mac      (pwr2_on_mac),
    .mac_pwr_state    (mac_pwr_state),
    .pwr_seq_busy     (pwr_seq_busy),
    .pwr_seq_done     (pwr_seq_done)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the domain is ON, OFF, or at position pos along a fixed-length ramp
  int   m_mode;
  int   m_pos;
  logic m_pend;
  logic m_idle_q;
  logic m_arm;
  logic m_wake;
  logic m_sleep;

  int   e_state;
  logic e_gate, e_iso, e_save, e_restore, e_pwr1, e_pwr2, e_busy, e_done;

  assign m_wake  = macb_wakeup | sw_wake_req;
  assign m_sleep = sw_sleep_req | (sleep_en & macb_idle_int & ~m_idle_q & m_arm);

  function automatic int code_of(input int mode, input int pos);
    if (mode == M_ON)  return 0;
    if (mode == M_OFF) return 6;
    if (mode == M_DOWN) begin
      if (pos < 2) return pos + 1;
      if (pos < 2 + SAVE_DLY) return 3;
      if (pos < 2 + SAVE_DLY + PWR_DLY) return 4;
      return 5;
    end
    if (pos < PWR_DLY) return 7;
    if (pos < 2 * PWR_DLY) return 8;
    return 9 + (pos - 2 * PWR_DLY);
  endfunction

  // {gate, iso, save, restore, pwr1_off, pwr2_off} as a function of progress along the ramp
  function automatic logic [5:0] ctl_of(input int mode, input int pos);
    logic g, i, s, r, p1, p2;
    g  = (mode == M_DOWN) || (mode == M_OFF) || (mode == M_UP && pos < UP_LEN - 1);
    i  = (mode == M_DOWN && pos >= 1) || (mode == M_OFF) || (mode == M_UP && pos < UP_LEN - 2);
    s  = (mode == M_DOWN) && (pos >= 2) && (pos < 2 + SAVE_DLY);
    r  = (mode == M_UP) && (pos == 2 * PWR_DLY);
    p2 = (mode == M_DOWN && pos >= 2 + SAVE_DLY) || (mode == M_OFF) || (mode == M_UP && pos < PWR_DLY);
    p1 = (mode == M_DOWN && pos >= 2 + SAVE_DLY + PWR_DLY) || (mode == M_OFF);
    return {g, i, s, r, p1, p2};
  endfunction

  always @(posedge pclk or negedge n_preset) begin
    if (!n_preset) begin
      m_mode <= M_ON; m_pos <= 0; m_pend <= 1'b0; m_idle_q <= 1'b0; m_arm <= 1'b0;
      e_state <= 0; e_gate <= 1'b0; e_iso <= 1'b0; e_save <= 1'b0; e_restore <= 1'b0;
      e_pwr1 <= 1'b1; e_pwr2 <= 1'b1; e_busy <= 1'b0; e_done <= 1'b0;
    end else begin
      e_state   <= code_of(m_mode, m_pos);
      e_done    <= (m_mode == M_ON || m_mode == M_OFF) && (code_of(m_mode, m_pos) != e_state);
      e_busy    <= (m_mode == M_DOWN) || (m_mode == M_UP);
      e_gate    <= ctl_of(m_mode, m_pos)[5];
      e_iso     <= ctl_of(m_mode, m_pos)[4];
      e_save    <= ctl_of(m_mode, m_pos)[3];
      e_restore <= ctl_of(m_mode, m_pos)[2];
      e_pwr1    <= ~ctl_of(m_mode, m_pos)[1];
      e_pwr2    <= ~ctl_of(m_mode, m_pos)[0];
      m_idle_q  <= macb_idle_int;
      m_arm     <= 1'b1;
      case (m_mode)
        M_ON: if (!m_wake && m_sleep) begin m_mode <= M_DOWN; m_pos <= 0; end
        M_DOWN: begin
          if (m_wake) m_pend <= 1'b1;
          if (m_pos == DOWN_LEN - 1) m_mode <= M_OFF;
          else m_pos <= m_pos + 1;
        end
        M_OFF: if (m_wake || m_pend) begin m_mode <= M_UP; m_pos <= 0; m_pend <= 1'b0; end
        default: begin
          if (m_pos == UP_LEN - 1) m_mode <= M_ON;
          else m_pos <= m_pos + 1;
        end
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge pclk) begin
    chk("m_state",   int'(mac_pwr_state),    e_state);
    chk("m_gate",    int'(gate_clk_mac),     int'(e_gate));
    chk("m_iso",     int'(isolate_mac),      int'(e_iso));
    chk("m_save",    int'(save_edge_mac),    int'(e_save));
    chk("m_restore", int'(restore_edge_mac), int'(e_restore));
    chk("m_pwr1",    int'(pwr1_on_mac),      int'(e_pwr1));
    chk("m_pwr2",    int'(pwr2_on_mac),      int'(e_pwr2));
    chk("m_busy",    int'(pwr_seq_busy),     int'(e_busy));
    chk("m_done",    int'(pwr_seq_done),     int'(e_done));
  end

  initial begin
    n_preset = 1'b0; sleep_en = 1'b0; macb_idle_int = 1'b0; macb_wakeup = 1'b0;
    sw_sleep_req = 1'b0; sw_wake_req = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_state", int'(mac_pwr_state), 0);
    chk("rst_pwr1", int'(pwr1_on_mac), 1);
    chk("rst_pwr2", int'(pwr2_on_mac), 1);
    chk("rst_gate", int'(gate_clk_mac), 0);
    #2 n_preset = 1'b1;
    repeat (3) @(negedge pclk);

    // Basic power-down from a software request
    sw_sleep_req = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      @(negedge pclk);
      sw_sleep_req = 1'b0;
      case (k)
        1:  chk("pd_busy_t1", int'(pwr_seq_busy), 0);
        2:  begin chk("pd_gate_t2", int'(gate_clk_mac), 1); chk("pd_busy_t2", int'(pwr_seq_busy), 1); end
        3:  chk("pd_iso_t3", int'(isolate_mac), 1);
        4:  chk("pd_save_t4", int'(save_edge_mac), 1);
        5:  chk("pd_save_t5", int'(save_edge_mac), 1);
        6:  begin chk("pd_save_t6", int'(save_edge_mac), 0); chk("pd_pwr2_t6", int'(pwr2_on_mac), 0); end
        13: chk("pd_pwr1_t13", int'(pwr1_on_mac), 1);
        14: chk("pd_pwr1_t14", int'(pwr1_on_mac), 0);
        21: chk("pd_busy_t21", int'(pwr_seq_busy), 1);
        22: begin
          chk("pd_state_t22", int'(mac_pwr_state), 6);
          chk("pd_done_t22", int'(pwr_seq_done), 1);
          chk("pd_busy_t22", int'(pwr_seq_busy), 0);
        end
        23: chk("pd_done_t23", int'(pwr_seq_done), 0);
        default: ;
      endcase
    end

    // Power-up from OFF on macb_wakeup
    macb_wakeup = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge pclk);
      macb_wakeup = 1'b0;
      case (k)
        2:  begin chk("pu_pwr1_w2", int'(pwr1_on_mac), 1); chk("pu_pwr2_w2", int'(pwr2_on_mac), 0); end
        9:  chk("pu_pwr2_w9", int'(pwr2_on_mac), 0);
        10: chk("pu_pwr2_w10", int'(pwr2_on_mac), 1);
        17: chk("pu_rest_w17", int'(restore_edge_mac), 0);
        18: begin chk("pu_rest_w18", int'(restore_edge_mac), 1); chk("pu_iso_w18", int'(isolate_mac), 1); end
        19: begin chk("pu_rest_w19", int'(restore_edge_mac), 0); chk("pu_iso_w19", int'(isolate_mac), 0); end
        20: chk("pu_gate_w20", int'(gate_clk_mac), 0);
        21: begin chk("pu_state_w21", int'(mac_pwr_state), 0); chk("pu_done_w21", int'(pwr_seq_done), 1); end
        default: ;
      endcase
    end

    // Idle-triggered sleep with sleep_en set, then software wake
    sleep_en = 1'b1; macb_idle_int = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge pclk);
      if (k == 2)  chk("idle_gate_t2", int'(gate_clk_mac), 1);
      if (k == 22) chk("idle_state_t22", int'(mac_pwr_state), 6);
    end
    sw_wake_req = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge pclk);
      sw_wake_req = 1'b0;
      if (k == 21) chk("idle_wake_on", int'(mac_pwr_state), 0);
    end
    macb_idle_int = 1'b0;
    @(negedge pclk);

    // Idle edge ignored with sleep_en clear
    sleep_en = 1'b0; macb_idle_int = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge pclk);
      chk("noen_state", int'(mac_pwr_state), 0);
      chk("noen_gate", int'(gate_clk_mac), 0);
    end
    macb_idle_int = 1'b0;

    // Wake during PWR2_OFF is held until OFF, then power-up follows on its own
    sw_sleep_req = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      @(negedge pclk);
      sw_sleep_req = 1'b0;
      sw_wake_req  = (k == 8);
      case (k)
        22: begin chk("wmid_state_t22", int'(mac_pwr_state), 6); chk("wmid_done_t22", int'(pwr_seq_done), 1); end
        23: chk("wmid_state_t23", int'(mac_pwr_state), 7);
        42: begin chk("wmid_state_t42", int'(mac_pwr_state), 0); chk("wmid_done_t42", int'(pwr_seq_done), 1); end
        default: ;
      endcase
    end

    // Sleep and wake together in ON: wake wins
    sw_sleep_req = 1'b1; sw_wake_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge pclk);
      sw_sleep_req = 1'b0; sw_wake_req = 1'b0;
      chk("both_busy", int'(pwr_seq_busy), 0);
      chk("both_state", int'(mac_pwr_state), 0);
    end

    // Sleep during PWR1_ON is dropped
    sw_sleep_req = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge pclk);
      sw_sleep_req = 1'b0;
    end
    chk("drop_off", int'(mac_pwr_state), 6);
    sw_wake_req = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge pclk);
      sw_wake_req  = 1'b0;
      sw_sleep_req = (k == 4);
      if (k == 21) chk("drop_on_w21", int'(mac_pwr_state), 0);
      if (k == 25) chk("drop_busy_w25", int'(pwr_seq_busy), 0);
    end

    // Reset asserted during PWR1_OFF
    sw_sleep_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge pclk);
      sw_sleep_req = 1'b0;
    end
    chk("rmid_pre_pwr1", int'(pwr1_on_mac), 0);
    #2 n_preset = 1'b0;
    #1;
    chk("rmid_state", int'(mac_pwr_state), 0);
    chk("rmid_pwr1", int'(pwr1_on_mac), 1);
    chk("rmid_pwr2", int'(pwr2_on_mac), 1);
    chk("rmid_iso", int'(isolate_mac), 0);
    chk("rmid_gate", int'(gate_clk_mac), 0);
    @(negedge pclk);
    #2 n_preset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge pclk);
      chk("rmid_after_busy", int'(pwr_seq_busy), 0);
    end

    // Idle already high at reset release produces no trigger
    sleep_en = 1'b1; macb_idle_int = 1'b1;
    @(negedge pclk);
    #2 n_preset = 1'b0;
    @(negedge pclk);
    #2 n_preset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge pclk);
      chk("idlerst_state", int'(mac_pwr_state), 0);
      chk("idlerst_busy", int'(pwr_seq_busy), 0);
    end

    // Randomized traffic checked by the model
    for (int n = 0; n < 4000; n++) begin
      @(negedge pclk);
      sw_sleep_req = ($urandom_range(0, 14) == 0);
      sw_wake_req  = ($urandom_range(0, 59) == 0);
      macb_wakeup  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 7) == 0) macb_idle_int = ~macb_idle_int;
      if ($urandom_range(0, 39) == 0) sleep_en = ~sleep_en;
      if ($urandom_range(0, 999) == 0) begin
        #2 n_preset = 1'b0;
        @(negedge pclk);
        #2 n_preset = 1'b1;
      end
    end

    sw_sleep_req = 1'b0; sw_wake_req = 1'b0; macb_wakeup = 1'b0;
    repeat (2) @(negedge pclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
